// File: rtl/pixel_scheduler_if.sv
// Bundle between pixel_scheduler, its depth engines and the downstream pixel writer.
// master = scheduler side, slave = engines/writer/frame control side.
interface pixel_scheduler_if #(
    parameter int N_ENG = 4
);
    logic               frame_start;
    logic [31:0]        re_origin;
    logic [31:0]        im_origin;
    logic [31:0]        step;
    logic [N_ENG-1:0]   eng_start;
    logic [9:0]         eng_x;
    logic [8:0]         eng_y;
    logic [31:0]        eng_re_c;
    logic [31:0]        eng_im_c;
    logic [N_ENG-1:0]   eng_done;
    logic [8*N_ENG-1:0] eng_depth;
    logic               out_valid;
    logic               out_ready;
    logic [9:0]         out_x;
    logic [8:0]         out_y;
    logic [7:0]         out_depth;
    logic               busy;
    logic               frame_done;

    modport master (
        input  frame_start, re_origin, im_origin, step, eng_done, eng_depth, out_ready,
        output eng_start, eng_x, eng_y, eng_re_c, eng_im_c,
        output out_valid, out_x, out_y, out_depth, busy, frame_done
    );

    modport slave (
        output frame_start, re_origin, im_origin, step, eng_done, eng_depth, out_ready,
        input  eng_start, eng_x, eng_y, eng_re_c, eng_im_c,
        input  out_valid, out_x, out_y, out_depth, busy, frame_done
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Walks a WIDTH x HEIGHT screen, dispatches each pixel to the lowest free depth engine, returns tagged depths.
// First eng_start one cycle after frame_start; a stalled out_ready holds the result and parks its engine.
module pixel_scheduler #(
    parameter int N_ENG  = 4,
    parameter int FRAC   = 16,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic              sysclk,
    input  logic              reset,
    pixel_scheduler_if.master bus
);
    localparam int         PW     = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    if (N_ENG < 1 || N_ENG > 8 || FRAC < 0 || FRAC > 31) begin : g_bad_param
        $error("pixel_scheduler: N_ENG must be 1..8 and FRAC 0..31");
    end

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;
    typedef enum logic [1:0] {E_FREE, E_BUSY, E_RESULT} eng_state_t;

    state_t           state_q;
    logic [9:0]       x_q;
    logic [8:0]       y_q;
    logic [31:0]      re_acc_q, im_acc_q, re_org_q, step_q;
    eng_state_t       est_q      [N_ENG];
    logic [9:0]       tag_x_q    [N_ENG];
    logic [8:0]       tag_y_q    [N_ENG];
    logic [7:0]       slot_dep_q [N_ENG];
    logic [N_ENG-1:0] slot_full_q, done_q, eng_start_q;
    logic [PW-1:0]    rr_q, lock_idx_q;
    logic             lock_q, busy_q, frame_done_q;
    logic [9:0]       eng_x_q;
    logic [8:0]       eng_y_q;
    logic [31:0]      eng_re_q, eng_im_q;

    logic             idle_go, do_disp, free_any, all_free, found, xfer;
    logic [PW-1:0]    free_idx, scan_idx, sel_idx, rr_d, j;
    logic [9:0]       cur_x;
    logic [8:0]       cur_y;
    logic [31:0]      cur_re, cur_im, org_re, stp;

    always_comb begin
        free_any = 1'b0;
        all_free = 1'b1;
        free_idx = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (est_q[i] == E_FREE) begin
                free_any = 1'b1;
                free_idx = PW'(i);
            end else begin
                all_free = 1'b0;
            end
        end
        found    = 1'b0;
        scan_idx = '0;
        j        = '0;
        for (int k = 0; k < N_ENG; k++) begin
            j = PW'((int'(rr_q) + k) % N_ENG);
            if (!found && slot_full_q[j]) begin
                found    = 1'b1;
                scan_idx = j;
            end
        end
    end

    // A stalled output keeps its slot even if an earlier slot in RR order fills meanwhile.
    assign sel_idx = lock_q ? lock_idx_q : scan_idx;
    assign rr_d    = (sel_idx == PW'(N_ENG - 1)) ? '0 : sel_idx + PW'(1);
    assign xfer    = bus.out_valid & bus.out_ready;

    // Pixel (0,0) leaves straight from IDLE so the first start follows frame_start by one cycle.
    assign idle_go = (state_q == S_IDLE) & bus.frame_start;
    assign do_disp = free_any & (idle_go | (state_q == S_SCAN));
    assign cur_x   = idle_go ? 10'd0 : x_q;
    assign cur_y   = idle_go ? 9'd0 : y_q;
    assign cur_re  = idle_go ? bus.re_origin : re_acc_q;
    assign cur_im  = idle_go ? bus.im_origin : im_acc_q;
    assign org_re  = idle_go ? bus.re_origin : re_org_q;
    assign stp     = idle_go ? bus.step : step_q;

    assign bus.eng_start  = eng_start_q;
    assign bus.eng_x      = eng_x_q;
    assign bus.eng_y      = eng_y_q;
    assign bus.eng_re_c   = eng_re_q;
    assign bus.eng_im_c   = eng_im_q;
    assign bus.out_valid  = |slot_full_q;
    assign bus.out_x      = tag_x_q[sel_idx];
    assign bus.out_y      = tag_y_q[sel_idx];
    assign bus.out_depth  = slot_dep_q[sel_idx];
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            re_acc_q     <= '0;
            im_acc_q     <= '0;
            re_org_q     <= '0;
            step_q       <= '0;
            slot_full_q  <= '0;
            done_q       <= '0;
            eng_start_q  <= '0;
            rr_q         <= '0;
            lock_idx_q   <= '0;
            lock_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            eng_re_q     <= '0;
            eng_im_q     <= '0;
            for (int i = 0; i < N_ENG; i++) begin
                est_q[i]      <= E_FREE;
                tag_x_q[i]    <= '0;
                tag_y_q[i]    <= '0;
                slot_dep_q[i] <= '0;
            end
        end else begin
            eng_start_q  <= '0;
            frame_done_q <= 1'b0;
            done_q       <= bus.eng_done;
            lock_q       <= bus.out_valid & ~bus.out_ready;
            lock_idx_q   <= sel_idx;

            // done is a level that stays high between pixels; only a fresh rise completes a pixel.
            for (int i = 0; i < N_ENG; i++) begin
                if (est_q[i] == E_BUSY && bus.eng_done[i] && !done_q[i]) begin
                    est_q[i]       <= E_RESULT;
                    slot_full_q[i] <= 1'b1;
                    slot_dep_q[i]  <= bus.eng_depth[8*i +: 8];
                end
            end

            if (xfer) begin
                est_q[sel_idx]       <= E_FREE;
                slot_full_q[sel_idx] <= 1'b0;
                rr_q                 <= rr_d;
            end

            if (idle_go) begin
                re_org_q <= bus.re_origin;
                step_q   <= bus.step;
                busy_q   <= 1'b1;
                state_q  <= S_SCAN;
            end

            if (do_disp) begin
                eng_start_q[free_idx] <= 1'b1;
                eng_x_q               <= cur_x;
                eng_y_q               <= cur_y;
                eng_re_q              <= cur_re;
                eng_im_q              <= cur_im;
                est_q[free_idx]       <= E_BUSY;
                tag_x_q[free_idx]     <= cur_x;
                tag_y_q[free_idx]     <= cur_y;
                if (cur_x == X_LAST) begin
                    x_q      <= '0;
                    re_acc_q <= org_re;
                    y_q      <= cur_y + 9'd1;
                    im_acc_q <= cur_im - stp;
                    if (cur_y == Y_LAST) begin
                        state_q <= S_DRAIN;
                    end
                end else begin
                    x_q      <= cur_x + 10'd1;
                    re_acc_q <= cur_re + stp;
                    y_q      <= cur_y;
                    im_acc_q <= cur_im;
                end
            end

            if (state_q == S_DRAIN && all_free && !(|slot_full_q)) begin
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler on a 4x2 screen with two behavioural engines of programmable latency.
module tb_pixel_scheduler;
    localparam int N = 2;

    typedef struct packed { logic [9:0] x; logic [8:0] y; logic [31:0] re; logic [31:0] im; } disp_t;
    typedef struct packed { logic [9:0] x; logic [8:0] y; logic [7:0] d; } res_t;
    typedef struct { int idx; disp_t exp; } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_scheduler_if #(.N_ENG(N)) bus ();
    pixel_scheduler #(.N_ENG(N), .FRAC(16), .WIDTH(4), .HEIGHT(2)) dut (
        .sysclk(clk), .reset(rst), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;
    disp_t disp_q[$];
    int    disp_eng_q[$];
    res_t  res_q[$];
    vec_t  tab [8];

    int         lat [N];
    logic [N-1:0] manual, man_done, m_done;
    logic [7:0] man_depth [N];
    logic [7:0] m_depth [N];
    int         cnt [N];

    function automatic logic [7:0] dfun(input logic [9:0] x, input logic [8:0] y);
        return 8'(32'(x) * 7 + 32'(y) * 50 + 3);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic disp_t get_disp(input int i);
        return (i < disp_q.size()) ? disp_q[i] : '0;
    endfunction

    function automatic res_t get_res(input int i);
        return (i < res_q.size()) ? res_q[i] : '0;
    endfunction

    // Behavioural engines: done falls the cycle after start and rises again lat cycles later.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_done[i] <= 1'b0;
                cnt[i]    <= 0;
                m_depth[i] <= '0;
            end else if (bus.eng_start[i]) begin
                m_done[i]  <= 1'b0;
                cnt[i]     <= lat[i];
                m_depth[i] <= dfun(bus.eng_x, bus.eng_y);
            end else if (cnt[i] > 0) begin
                cnt[i] <= cnt[i] - 1;
                if (cnt[i] == 1) m_done[i] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_eng
        assign bus.eng_done[g]        = manual[g] ? man_done[g] : m_done[g];
        assign bus.eng_depth[8*g +: 8] = manual[g] ? man_depth[g] : m_depth[g];
    end

    logic        prev_stall = 1'b0;
    logic [26:0] prev_out = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.eng_start != '0) begin
                chk("onehot_start", 128'($onehot(bus.eng_start)), 128'(1));
                disp_q.push_back(disp_t'({bus.eng_x, bus.eng_y, bus.eng_re_c, bus.eng_im_c}));
                disp_eng_q.push_back(bus.eng_start[1] ? 1 : 0);
            end
            if (prev_stall)
                chk("stable_out", 128'({bus.out_valid, bus.out_x, bus.out_y, bus.out_depth}),
                    128'({1'b1, prev_out}));
            if (bus.out_valid && bus.out_ready)
                res_q.push_back(res_t'({bus.out_x, bus.out_y, bus.out_depth}));
            if (bus.frame_done) fd_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_x, bus.out_y, bus.out_depth};
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic start_frame(output int fd0);
        disp_q.delete(); disp_eng_q.delete(); res_q.delete();
        fd0 = fd_cnt;
        @(posedge clk); #1 bus.frame_start = 1'b1;
        @(posedge clk); #1 bus.frame_start = 1'b0;
        #1 chk("first_start", 128'(bus.eng_start), 128'(1));
    endtask

    task automatic wait_frame(input int fd0, input string tag);
        int n = 0;
        while (fd_cnt == fd0 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_frame_done"}, 128'(fd_cnt - fd0), 128'(1));
        chk({tag, "_results_at_done"}, 128'(res_q.size()), 128'(8));
        chk({tag, "_busy_after"}, 128'({bus.busy, bus.frame_done}), 128'(0));
    endtask

    task automatic check_frame(input string tag);
        int c;
        res_t r;
        chk({tag, "_ndisp"}, 128'(disp_q.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_disp%0d", tag, tab[i].idx), 128'(get_disp(tab[i].idx)), 128'(tab[i].exp));
            c = 0;
            r = '0;
            foreach (res_q[k]) begin
                if (res_q[k].x == tab[i].exp.x && res_q[k].y == tab[i].exp.y) begin
                    c++;
                    r = res_q[k];
                end
            end
            chk($sformatf("%s_once%0d", tag, i), 128'(c), 128'(1));
            chk($sformatf("%s_depth%0d", tag, i), 128'(r.d), 128'(dfun(tab[i].exp.x, tab[i].exp.y)));
        end
    endtask

    initial begin
        int fd0;
        int n1;
        int zeros;
        res_t r;

        tab[0] = '{0, disp_t'({10'd0, 9'd0, 32'hFFFE0000, 32'h00010000})};
        tab[1] = '{1, disp_t'({10'd1, 9'd0, 32'hFFFE4000, 32'h00010000})};
        tab[2] = '{2, disp_t'({10'd2, 9'd0, 32'hFFFE8000, 32'h00010000})};
        tab[3] = '{3, disp_t'({10'd3, 9'd0, 32'hFFFEC000, 32'h00010000})};
        tab[4] = '{4, disp_t'({10'd0, 9'd1, 32'hFFFE0000, 32'h0000C000})};
        tab[5] = '{5, disp_t'({10'd1, 9'd1, 32'hFFFE4000, 32'h0000C000})};
        tab[6] = '{6, disp_t'({10'd2, 9'd1, 32'hFFFE8000, 32'h0000C000})};
        tab[7] = '{7, disp_t'({10'd3, 9'd1, 32'hFFFEC000, 32'h0000C000})};

        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.re_origin = 32'hFFFE0000;
        bus.im_origin = 32'h00010000;
        bus.step      = 32'h00004000;
        bus.out_ready = 1'b1;
        lat[0] = 3; lat[1] = 3;
        manual = '0; man_done = '0;
        man_depth[0] = '0; man_depth[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_ctrl", 128'({bus.eng_start, bus.busy, bus.frame_done, bus.out_valid}), 128'(0));
        chk("reset_out", 128'({bus.out_x, bus.out_y, bus.out_depth}), 128'(0));
        chk("reset_bus", 128'({bus.eng_x, bus.eng_y, bus.eng_re_c, bus.eng_im_c}), 128'(0));

        // Basic frame
        start_frame(fd0);
        chk("basic_busy", 128'(bus.busy), 128'(1));
        wait_frame(fd0, "basic");
        check_frame("basic");

        // Unequal latencies: engine 1 keeps taking pixels while engine 0 works
        lat[0] = 10; lat[1] = 2;
        start_frame(fd0);
        wait_frame(fd0, "order");
        check_frame("order");
        n1 = 0; zeros = 0;
        foreach (disp_eng_q[k]) begin
            if (disp_eng_q[k] == 0) zeros++;
            else if (zeros == 1) n1++;
        end
        chk("order_eng1_multi", 128'(n1 >= 2), 128'(1));
        r = get_res(0);
        chk("order_first_result", 128'({r.x, r.y}), 128'({10'd1, 9'd0}));

        // Backpressure
        lat[0] = 3; lat[1] = 3;
        do_reset();
        bus.out_ready = 1'b0;
        start_frame(fd0);
        repeat (20) @(posedge clk);
        #2;
        chk("bp_ndisp", 128'(disp_q.size()), 128'(2));
        chk("bp_nres", 128'(res_q.size()), 128'(0));
        chk("bp_head", 128'({bus.out_valid, bus.out_x, bus.out_y}), 128'({1'b1, 10'd0, 9'd0}));
        bus.out_ready = 1'b1;
        wait_frame(fd0, "bp");
        check_frame("bp");
        r = get_res(1);
        chk("bp_second", 128'({r.x, r.y}), 128'({10'd1, 9'd0}));

        // Done held high between pixels
        do_reset();
        manual = 2'b11; man_done = 2'b11;
        bus.out_ready = 1'b0;
        start_frame(fd0);
        repeat (10) @(posedge clk);
        #2;
        chk("lvl_no_result", 128'(bus.out_valid), 128'(0));
        chk("lvl_ndisp", 128'(disp_q.size()), 128'(2));
        @(posedge clk); #1 man_done[0] = 1'b0;
        @(posedge clk); #1 man_done[0] = 1'b1; man_depth[0] = 8'h5A;
        @(posedge clk); #2;
        chk("lvl_first", 128'({bus.out_valid, bus.out_x, bus.out_y, bus.out_depth}),
            128'({1'b1, 10'd0, 9'd0, 8'h5A}));
        bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("lvl_no_dup", 128'({bus.out_valid, 32'(res_q.size()), 32'(disp_q.size())}),
            128'({1'b0, 32'd1, 32'd3}));
        @(posedge clk); #1 man_done[0] = 1'b0;
        @(posedge clk); #1 man_done[0] = 1'b1; man_depth[0] = 8'h33;
        @(posedge clk); #2;
        chk("lvl_second", 128'({bus.out_valid, bus.out_x, bus.out_y, bus.out_depth}),
            128'({1'b1, 10'd2, 9'd0, 8'h33}));
        do_reset();
        manual = '0;
        bus.out_ready = 1'b1;

        // Reset in the middle of a frame
        start_frame(fd0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #2;
        chk("abort_ctrl", 128'({bus.eng_start, bus.busy, bus.frame_done, bus.out_valid}), 128'(0));
        chk("abort_bus", 128'({bus.out_x, bus.out_y, bus.out_depth, bus.eng_x, bus.eng_y,
            bus.eng_re_c, bus.eng_im_c}), 128'(0));
        rst = 1'b0;
        disp_q.delete(); res_q.delete();
        repeat (20) @(posedge clk);
        #2;
        chk("abort_quiet", 128'({32'(res_q.size()), 32'(disp_q.size()), bus.busy}), 128'(0));
        start_frame(fd0);
        wait_frame(fd0, "after_abort");
        check_frame("after_abort");

        // frame_start with a new origin mid-frame is ignored
        start_frame(fd0);
        repeat (3) @(posedge clk);
        #1 bus.frame_start = 1'b1;
        bus.re_origin = 32'h12345678;
        bus.im_origin = 32'h00000000;
        bus.step      = 32'h00010000;
        @(posedge clk); #1 bus.frame_start = 1'b0;
        wait_frame(fd0, "restart");
        check_frame("restart");
        repeat (30) @(posedge clk);
        #2;
        chk("restart_one_done", 128'({32'(fd_cnt - fd0), bus.busy}), 128'({32'd1, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Frame-level controller that sequences a bank of N_ENG depth-calculator engines across a WIDTH x HEIGHT screen.
- Generates per-pixel (x, y, re_c, im_c) from a frame configuration.
- Dispatches each pixel to the lowest-index free engine.
- Captures each engine's final_depth and returns tagged results on a valid/ready stream towards the pixel writer. Results leave in completion order, not raster order.

Parameters:
N_ENG, 4, number of attached depth engines (1..8)
FRAC, 16, fractional bits of the Q-format coordinates (matches engines)
WIDTH, 640, pixels per line (x width 10)
HEIGHT, 480, lines per frame (y width 9)

Ports:
sysclk  in  1  clock
reset  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse that begins a frame; ignored while busy=1
re_origin  in  32  signed Q(32-FRAC).FRAC real part of pixel (0,0); sampled on accepted frame_start
im_origin  in  32  signed imaginary part of pixel (0,0); sampled likewise
step  in  32  signed per-pixel increment; sampled likewise
eng_start  out  N_ENG  one-hot, one-cycle start pulse to an engine
eng_x  out  10  pixel x, shared bus, valid in eng_start cycle
eng_y  out  9  pixel y, shared bus
eng_re_c  out  32  real c, shared bus
eng_im_c  out  32  imaginary c, shared bus
eng_done  in  N_ENG  engine done levels (high from completion until the cycle after its next start)
eng_depth  in  8*N_ENG  engine final_depth, engine i at bits [8i+7:8i]
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_x  out  10  result pixel x
out_y  out  9  result pixel y
out_depth  out  8  result depth
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse, last result of the frame transferred

Behaviour:
- Reset values: all outputs 0. Per-engine state FREE, slots empty, scan counters 0, RR pointer 0, done_q 0.
- Reset mid-frame aborts the frame. No pending result is emitted afterwards. Engines share the same reset.

Top FSM: IDLE, SCAN, DRAIN.
- IDLE: frame_start=1 latches config. Sets x=0, y=0, re_acc=re_origin, im_acc=im_origin, busy=1. Goes to SCAN.
- SCAN: each cycle, if any engine is FREE, dispatch the current pixel to the lowest-index FREE engine.
  - Dispatch pulses eng_start[i] for exactly one cycle, drives the buses, and marks engine i BUSY with tag (x,y).
  - Advance after dispatch: x+1 and re_acc+=step. At x=WIDTH-1: x=0, re_acc=re_origin, y+1, im_acc-=step.
  - After dispatching pixel (WIDTH-1,HEIGHT-1), go to DRAIN.
  - At most one dispatch per cycle. If no engine is FREE, stall with no start and no counter change.
- Coordinate arithmetic:
  - re_c = re_origin + x*step; im_c = im_origin - y*step (screen y grows downward).
  - Computed incrementally, 32-bit two's-complement, wrap on overflow, no saturation.
- DRAIN: when all engines are FREE and all slots are empty, pulse frame_done for one cycle, clear busy, return to IDLE.
- First eng_start is asserted the cycle after the accepted frame_start.

Completion:
- done_q registers eng_done each cycle. Completion of a BUSY engine i is eng_done[i]=1 & done_q[i]=0.
- Rising-edge detection is required because done stays high between pixels and falls the cycle after start.
- On completion, the cycle after the edge, slot i = {tag, eng_depth[i]}, full, and engine i becomes RESULT.
- A completion edge for an engine not BUSY is ignored.

Output:
- out_valid = any slot full.
- Selected slot = first full slot at or after the RR pointer (round-robin). out_x/out_y/out_depth come combinationally from the selected slot.
- Transfer on out_valid & out_ready: slot cleared, engine i FREE next cycle, RR pointer = i+1 mod N_ENG.
- The freed engine may be dispatched on the cycle after the transfer. A completion and a transfer of different engines in the same cycle are both honoured.
- out_* must be held stable while out_valid=1 and out_ready=0.
- frame_start while busy=1 is ignored. Config changes mid-frame have no effect.

Test Plan:
- Bench setup: WIDTH=4, HEIGHT=2, N_ENG=2, FRAC=16, behavioural engines with programmable latency. Config: re_origin=0xFFFE0000 (-2.0), im_origin=0x00010000 (1.0), step=0x00004000 (0.25).
- Basic frame, latency 3, out_ready=1 -> 8 results, each (x,y) exactly once. Pixel (3,1) is dispatched with re_c=0xFFFEC000 and im_c=0x0000C000. One frame_done pulse follows the 8th transfer, busy=0 the next cycle.
- Dispatch order, engine 0 latency 10 and engine 1 latency 2 -> engine 1 takes multiple pixels while engine 0 is busy. Results arrive out of raster order with correct tags. Never two eng_start bits in one cycle.
- Backpressure, out_ready=0 for 20 cycles -> at most 2 results pending, no eng_start after both engines hold results, out_* stable. Releasing out_ready drains the results round-robin (slot 0 then slot 1 when both are full with pointer 0).
- Done-level handling: engine done stays high between pixels -> no duplicate result. A second pixel's result is accepted only after a fresh rising edge.
- Reset at cycle 7 of a frame -> the next cycle has all outputs 0 and busy=0. A new frame_start runs a complete 8-pixel frame normally.
- frame_start pulsed again mid-frame with different origin -> ignored. Remaining pixels use the original config, with exactly one frame_done.
